// File: rtl/pipe_stage.sv
// Pipeline register between two core stages; loads, holds or bubbles its bundle
// according to the global hazard code and this instance's stage position.
module pipe_stage #(
   parameter int                        STAGE       = 1,
   parameter int unsigned               WIDTH       = 32,
   parameter logic [WIDTH-1:0]          FLUSH_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       hazard_signal,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_data
);

   localparam int STAGE_ID  = 1;
   localparam int STAGE_EX  = 2;

   localparam logic [3:0] HS_DN       = 4'd0;
   localparam logic [3:0] STALL_EARLY = 4'd1;
   localparam logic [3:0] FLUSH_EARLY = 4'd2;
   localparam logic [3:0] STALL_MMU   = 4'd3;
   localparam logic [3:0] FLUSH_ALL   = 4'd4;

   // Stage role flags; any stage outside IF/ID and ID/EX behaves as a late stage
   localparam bit IS_ID = (STAGE == STAGE_ID);
   localparam bit IS_EX = (STAGE == STAGE_EX);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= FLUSH_VALUE;
      end else begin
         data_q <= data_d;
      end
   end

   // Next-value select; unknown codes fall through to a normal load
   always_comb begin
      data_d = in_data;
      case (hazard_signal)
         HS_DN:     data_d = in_data;
         FLUSH_ALL: data_d = FLUSH_VALUE;
         STALL_MMU: data_d = data_q;
         STALL_EARLY: begin
            if (IS_ID) begin
               data_d = data_q;
            end else if (IS_EX) begin
               data_d = FLUSH_VALUE;
            end
         end
         FLUSH_EARLY: begin
            if (IS_ID) begin
               data_d = FLUSH_VALUE;
            end
         end
         default:   data_d = in_data;
      endcase
   end

   assign out_data = data_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench: several pipe_stage instances (each stage, an out-of-range
// stage, custom flush value) compared against a rule-based reference model.
module tb_pipe_stage;

   localparam int N = 7;
   localparam int ST [N] = '{1, 2, 3, 4, 7, 2, 1};
   localparam logic [31:0] FVS [N] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                       32'h13, 32'h13};

   logic        clk;
   logic        rst;
   logic [3:0]  hazard_signal;
   logic [31:0] in_data;
   logic [31:0] out [N];
   logic [31:0] exp_q [N];

   int checks;
   int errors;

   for (genvar g = 0; g < N; g++) begin : g_dut
      pipe_stage #(
         .STAGE       (ST[g]),
         .WIDTH       (32),
         .FLUSH_VALUE (FVS[g])
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .hazard_signal (hazard_signal),
         .in_data       (in_data),
         .out_data      (out[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: what a pipeline register at this stage must present after the edge
   function automatic logic [31:0] model(input int stage, input logic [3:0] code,
                                         input logic [31:0] cur, input logic [31:0] din,
                                         input logic [31:0] fv);
      bit hold;
      bit bubble;
      hold   = (code == 4'd3) || (code == 4'd1 && stage == 1);
      bubble = (code == 4'd4) || (code == 4'd1 && stage == 2) ||
               (code == 4'd2 && stage == 1);
      if (bubble) return fv;
      if (hold)   return cur;
      return din;
   endfunction

   // One clock edge with the given code and data; inputs change 1 time unit after the edge
   task automatic cycle(input logic [3:0] code, input logic [31:0] din);
      hazard_signal = code;
      in_data       = din;
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < N; i++)
            exp_q[i] = model(ST[i], code, exp_q[i], din, FVS[i]);
      end
      #1;
   endtask

   task automatic check_all(input string name);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s inst%0d(stage %0d): got %h expected %h",
                     name, i, ST[i], out[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      cycle(4'd0, 32'hDEADBEEF);
      check_all("reset_preload");
      #2;
      rst = 1'b1;
      #1;
      for (int i = 0; i < N; i++) exp_q[i] = FVS[i];
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out[i] !== FVS[i]) begin
            errors++;
            $display("FAIL reset_async inst%0d: got %h expected %h", i, out[i], FVS[i]);
         end
      end
      cycle(4'd0, 32'h12345678);
      cycle(4'd3, 32'h87654321);
      check_all("reset_hold");
      #2;
      rst = 1'b0;
      cycle(4'd0, 32'h00000042);
      check_all("reset_first_load");
   endtask

   task automatic test_pass_through();
      for (int v = 1; v <= 3; v++) begin
         cycle(4'd0, 32'(v));
         check_all("pass_through");
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (out[i] !== 32'(v)) begin
               errors++;
               $display("FAIL pass_const stage%0d: got %h expected %h", ST[i], out[i], v);
            end
         end
      end
   endtask

   task automatic test_mmu_stall();
      cycle(4'd0, 32'hA5);
      for (int c = 0; c < 3; c++) begin
         cycle(4'd3, 32'h5A);
         check_all("mmu_stall");
         for (int i = 0; i < N; i++) begin
            checks++;
            if (out[i] !== 32'hA5) begin
               errors++;
               $display("FAIL mmu_hold inst%0d: got %h expected 000000a5", i, out[i]);
            end
         end
      end
      cycle(4'd0, 32'h5A);
      check_all("mmu_release");
   endtask

   task automatic test_load_use();
      logic [31:0] want [4];
      want = '{32'h11, 32'h0, 32'h77, 32'h77};
      cycle(4'd0, 32'h11);
      cycle(4'd1, 32'h77);
      check_all("load_use");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out[i] !== want[i]) begin
            errors++;
            $display("FAIL load_use_const stage%0d: got %h expected %h", ST[i], out[i], want[i]);
         end
      end
   endtask

   task automatic test_early_flush();
      logic [31:0] want [4];
      want = '{32'h0, 32'h33, 32'h33, 32'h33};
      cycle(4'd0, 32'h44);
      cycle(4'd2, 32'h33);
      check_all("early_flush");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out[i] !== want[i]) begin
            errors++;
            $display("FAIL early_flush_const stage%0d: got %h expected %h", ST[i], out[i], want[i]);
         end
      end
   endtask

   task automatic test_full_flush();
      cycle(4'd0, 32'hCAFE0001);
      cycle(4'd4, 32'hCAFE0002);
      check_all("full_flush");
      for (int i = 5; i < N; i++) begin
         checks++;
         if (out[i] !== 32'h00000013) begin
            errors++;
            $display("FAIL full_flush_custom inst%0d: got %h expected 00000013", i, out[i]);
         end
      end
   endtask

   task automatic test_undefined_code();
      cycle(4'd3, 32'h0);
      cycle(4'd9, 32'h99);
      check_all("undef_code");
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out[i] !== 32'h99) begin
            errors++;
            $display("FAIL undef_code_const inst%0d: got %h expected 00000099", i, out[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] code;
      for (int c = 0; c < 300; c++) begin
         if ($urandom_range(0, 3) == 0) code = 4'($urandom_range(5, 15));
         else                           code = 4'($urandom_range(0, 4));
         cycle(code, $urandom);
         check_all("random");
         if ($urandom_range(0, 40) == 0) begin
            #2;
            rst = 1'b1;
            #1;
            for (int i = 0; i < N; i++) exp_q[i] = FVS[i];
            check_all("random_reset");
            cycle(4'd0, $urandom);
            check_all("random_reset_hold");
            #2;
            rst = 1'b0;
         end
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      hazard_signal = 4'd0;
      in_data       = 32'h0;
      for (int i = 0; i < N; i++) exp_q[i] = FVS[i];
      #12;
      check_all("reset_initial");
      rst = 1'b0;
      test_reset();
      test_pass_through();
      test_mmu_stall();
      test_load_use();
      test_early_flush();
      test_full_flush();
      test_undefined_code();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
